// File: rtl/wavegen_pkg.sv
// Shared definitions for the DDS waveform generator: waveform select codes
// and the signed saturation helper used by the gain stage.
package wavegen_pkg;

    localparam logic [1:0] WAVE_TRI = 2'd0;
    localparam logic [1:0] WAVE_SAW = 2'd1;
    localparam logic [1:0] WAVE_SQR = 2'd2;
    localparam logic [1:0] WAVE_OFF = 2'd3;

    // Clamp a signed 32-bit value into the range of a w-bit signed word.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                      input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 32'd1));
        if (x > hi) begin
            sat_signed = hi;
        end else if (x < lo) begin
            sat_signed = lo;
        end else begin
            sat_signed = x;
        end
    endfunction

endpackage

// File: rtl/wavegen_shaper.sv
// Combinational waveform shaping: raw triangle/saw/square/silence from the
// phase MSBs, plus the amplitude gain with saturation for the next stage.
module wavegen_shaper
    import wavegen_pkg::*;
#(
    parameter int W = 12,
    parameter int A = 8
) (
    input  logic        [W:0]   phase_top,
    input  logic        [1:0]   sel,
    input  logic        [W-1:0] duty,
    input  logic signed [W-1:0] raw_in,
    input  logic        [A-1:0] amp,
    output logic signed [W-1:0] raw,
    output logic signed [W-1:0] scaled
);

    localparam int PW = W + A + 1;

    localparam logic [W-1:0] POS_FULL = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_FULL = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0]         u_s;
    logic [W-1:0]         v_s;
    logic [W-1:0]         fold_s;
    logic signed [PW-1:0] raw_ext_s;
    logic signed [PW-1:0] amp_ext_s;
    logic signed [PW-1:0] prod_s;
    logic signed [PW-1:0] shifted_s;
    logic signed [31:0]   wide_s;
    logic signed [31:0]   sat_s;

    assign u_s = phase_top[W:1];
    assign v_s = phase_top[W-1:0];

    // Raw waveform; subtracting 2^(W-1) from an unsigned word is an MSB flip.
    always_comb begin
        fold_s = phase_top[W] ? ~v_s : v_s;
        case (sel)
            WAVE_SAW: raw = {~u_s[W-1], u_s[W-2:0]};
            WAVE_TRI: raw = {~fold_s[W-1], fold_s[W-2:0]};
            WAVE_SQR: raw = (u_s < duty) ? POS_FULL : NEG_FULL;
            WAVE_OFF: raw = {W{1'b0}};
            default:  raw = {W{1'b0}};
        endcase
    end

    // Gain: amp is unsigned, unity at 2^(A-1); the shift floors toward -inf.
    always_comb begin
        raw_ext_s = PW'(raw_in);
        amp_ext_s = PW'({1'b0, amp});
        prod_s    = raw_ext_s * amp_ext_s;
        shifted_s = prod_s >>> (A - 1);
        wide_s    = 32'(shifted_s);
        sat_s     = sat_signed(wide_s, W);
        scaled    = sat_s[W-1:0];
    end

endmodule

// File: rtl/wavegen_dds.sv
// DDS waveform generator: prescaled sample tick, phase accumulator with sync,
// wrap-aligned waveform/duty latching and a two-stage shaping pipeline.
module wavegen_dds
    import wavegen_pkg::*;
#(
    parameter int C_pcm_bits   = 12,
    parameter int C_phase_bits = 24,
    parameter int C_amp_bits   = 8,
    parameter int C_div        = 1024
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic        [C_phase_bits-1:0] ftw,
    input  logic        [1:0]            wave_sel,
    input  logic        [C_pcm_bits-1:0] duty,
    input  logic        [C_amp_bits-1:0] amp,
    input  logic                         sync,
    output logic signed [C_pcm_bits-1:0] pcm,
    output logic                         pcm_valid,
    output logic                         wrap
);

    localparam int W  = C_pcm_bits;
    localparam int P  = C_phase_bits;
    localparam int A  = C_amp_bits;
    localparam int CW = $clog2(C_div);
    localparam logic [CW-1:0] DIV_LAST = CW'(C_div - 1);

    logic [CW-1:0]       presc_r;
    logic [P-1:0]        phase_r;
    logic [1:0]          sel_r;
    logic [W-1:0]        duty_r;
    logic                wrap_r;
    logic signed [W-1:0] raw_r;
    logic                st1_valid_r;
    logic signed [W-1:0] pcm_r;
    logic                pcm_valid_r;

    logic                tick_s;
    logic [P-1:0]        sum_s;
    logic                carry_s;
    logic [P-1:0]        phase_next_s;
    logic                wrap_next_s;
    logic                latch_s;
    logic [1:0]          sel_next_s;
    logic [W-1:0]        duty_next_s;
    logic signed [W-1:0] raw_s;
    logic signed [W-1:0] scaled_s;

    assign tick_s = (presc_r == DIV_LAST);

    // Next phase, wrap and latched controls as they would be after this tick.
    always_comb begin
        {carry_s, sum_s} = {1'b0, phase_r} + {1'b0, ftw};
        if (sync) begin
            phase_next_s = {P{1'b0}};
            wrap_next_s  = 1'b1;
        end else begin
            phase_next_s = sum_s;
            wrap_next_s  = carry_s;
        end
        latch_s = wrap_next_s || (sel_r == WAVE_OFF);
        if (latch_s) begin
            sel_next_s  = wave_sel;
            duty_next_s = duty;
        end else begin
            sel_next_s  = sel_r;
            duty_next_s = duty_r;
        end
    end

    wavegen_shaper #(
        .W (W),
        .A (A)
    ) u_shaper (
        .phase_top (phase_next_s[P-1 -: W+1]),
        .sel       (sel_next_s),
        .duty      (duty_next_s),
        .raw_in    (raw_r),
        .amp       (amp),
        .raw       (raw_s),
        .scaled    (scaled_s)
    );

    // Sample-rate prescaler.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            presc_r <= {CW{1'b0}};
        end else if (tick_s) begin
            presc_r <= {CW{1'b0}};
        end else begin
            presc_r <= presc_r + CW'(1);
        end
    end

    // Phase accumulator, control latching and stage-1 raw sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_r     <= {P{1'b0}};
            sel_r       <= WAVE_OFF;
            duty_r      <= {W{1'b0}};
            wrap_r      <= 1'b0;
            raw_r       <= {W{1'b0}};
            st1_valid_r <= 1'b0;
        end else if (tick_s) begin
            phase_r     <= phase_next_s;
            sel_r       <= sel_next_s;
            duty_r      <= duty_next_s;
            wrap_r      <= wrap_next_s;
            raw_r       <= raw_s;
            st1_valid_r <= 1'b1;
        end else begin
            wrap_r      <= 1'b0;
            st1_valid_r <= 1'b0;
        end
    end

    // Stage 2: scaled, saturated sample held between valid strobes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pcm_r       <= {W{1'b0}};
            pcm_valid_r <= 1'b0;
        end else begin
            pcm_valid_r <= st1_valid_r;
            if (st1_valid_r) begin
                pcm_r <= scaled_s;
            end
        end
    end

    assign pcm       = pcm_r;
    assign pcm_valid = pcm_valid_r;
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_wavegen_dds.sv
// Self-checking bench for wavegen_dds: directed scenarios plus randomized
// traffic compared against an arithmetic reference model.
module tb_wavegen_dds;

    localparam int DIV = 4;
    localparam longint PMOD = 64'sd16777216;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic        [23:0] ftw = 24'd0;
    logic        [1:0]  wave_sel = 2'd3;
    logic        [11:0] duty = 12'd0;
    logic        [7:0]  amp = 8'd128;
    logic               sync = 1'b0;
    logic signed [11:0] pcm;
    logic               pcm_valid;
    logic               wrap;

    int n_total = 0;
    int n_bad = 0;
    int samp[$];
    int vcyc[$];
    int wcyc[$];

    wavegen_dds #(
        .C_pcm_bits   (12),
        .C_phase_bits (24),
        .C_amp_bits   (8),
        .C_div        (DIV)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .ftw       (ftw),
        .wave_sel  (wave_sel),
        .duty      (duty),
        .amp       (amp),
        .sync      (sync),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic longint nxt_ph(longint ph, longint f, logic s);
        if (s) return 0;
        return (ph + f) % PMOD;
    endfunction

    function automatic bit nxt_wr(longint ph, longint f, logic s);
        return s || ((ph + f) >= PMOD);
    endfunction

    function automatic int ref_raw(longint ph, int sel, int dty);
        int u;
        int v;
        u = int'(ph / 4096);
        v = int'((ph / 2048) % 4096);
        case (sel)
            0: return (ph >= 64'sd8388608) ? (4095 - v) - 2048 : v - 2048;
            1: return u - 2048;
            2: return (u < dty) ? 2047 : -2048;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_gain(int raw, int a);
        longint p;
        longint q;
        p = longint'(raw) * longint'(a);
        q = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
        return int'(q);
    endfunction

    int                 m_cnt;
    longint             m_phase;
    int                 m_sel;
    int                 m_duty;
    int                 m_raw;
    bit                 m_st1;
    logic signed [11:0] exp_pcm;
    logic               exp_valid;
    logic               exp_wrap;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_cnt <= 0; m_phase <= 0; m_sel <= 3; m_duty <= 0; m_raw <= 0; m_st1 <= 1'b0;
            exp_pcm <= 12'sd0; exp_valid <= 1'b0; exp_wrap <= 1'b0;
        end else begin
            exp_valid <= m_st1;
            if (m_st1) exp_pcm <= 12'(ref_gain(m_raw, int'(amp)));
            if (m_cnt == DIV - 1) begin
                m_cnt    <= 0;
                m_st1    <= 1'b1;
                m_phase  <= nxt_ph(m_phase, longint'(ftw), sync);
                exp_wrap <= nxt_wr(m_phase, longint'(ftw), sync);
                if (nxt_wr(m_phase, longint'(ftw), sync) || m_sel == 3) begin
                    m_sel  <= int'(wave_sel);
                    m_duty <= int'(duty);
                    m_raw  <= ref_raw(nxt_ph(m_phase, longint'(ftw), sync), int'(wave_sel), int'(duty));
                end else begin
                    m_raw  <= ref_raw(nxt_ph(m_phase, longint'(ftw), sync), m_sel, m_duty);
                end
            end else begin
                m_cnt    <= m_cnt + 1;
                m_st1    <= 1'b0;
                exp_wrap <= 1'b0;
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic do_reset(input logic [1:0] sel, input logic [23:0] f,
                            input logic [11:0] d, input logic [7:0] a);
        @(negedge clk);
        rstn = 1'b0;
        wave_sel = sel; ftw = f; duty = d; amp = a; sync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic collect(input int n, input int budget);
        samp.delete(); vcyc.delete(); wcyc.delete();
        for (int i = 0; i < budget && samp.size() < n; i++) begin
            @(negedge clk);
            if (pcm_valid) begin
                samp.push_back(int'(pcm));
                vcyc.push_back(i);
            end
            if (wrap) wcyc.push_back(i);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        #12;
        n_total++;
        if (pcm !== 12'sd0 || pcm_valid !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got pcm=%0d valid=%b wrap=%b want 0/0/0", pcm, pcm_valid, wrap);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (pcm_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_no_early_valid: cycle %0d got valid=%b want 0", i, pcm_valid);
            end
        end
    endtask

    task automatic test_saw();
        do_reset(2'd1, 24'h100000, 12'd0, 8'd128);
        collect(16, 100);
        n_total++;
        if (samp.size() != 16) begin
            n_bad++;
            $display("FAIL saw_count: got %0d samples want 16", samp.size());
        end else begin
            n_total += 6;
            if (samp[0] != -1792) begin n_bad++; $display("FAIL saw_first: got %0d want -1792", samp[0]); end
            if (samp[1] != -1536) begin n_bad++; $display("FAIL saw_second: got %0d want -1536", samp[1]); end
            if (samp[2] != -1280) begin n_bad++; $display("FAIL saw_third: got %0d want -1280", samp[2]); end
            if (samp[15] != -2048) begin n_bad++; $display("FAIL saw_wrap_value: got %0d want -2048", samp[15]); end
            if (vcyc[1] - vcyc[0] != DIV) begin
                n_bad++; $display("FAIL saw_spacing: got %0d want %0d", vcyc[1] - vcyc[0], DIV);
            end
            if (wcyc.size() != 1 || wcyc[0] != vcyc[15] - 1) begin
                n_bad++;
                $display("FAIL saw_wrap_pulse: got %0d pulses (first at %0d) want 1 at %0d",
                         wcyc.size(), (wcyc.size() > 0) ? wcyc[0] : -1, vcyc[15] - 1);
            end
        end
    endtask

    task automatic test_triangle();
        int exp_tri[16] = '{-1536, -1024, -512, 0, 512, 1024, 1536, 2047,
                            1535, 1023, 511, -1, -513, -1025, -1537, -2048};
        do_reset(2'd0, 24'h100000, 12'd0, 8'd128);
        collect(16, 100);
        n_total++;
        if (samp.size() != 16) begin
            n_bad++;
            $display("FAIL tri_count: got %0d samples want 16", samp.size());
        end else begin
            for (int k = 0; k < 16; k++) begin
                n_total++;
                if (samp[k] != exp_tri[k]) begin
                    n_bad++;
                    $display("FAIL tri_sample[%0d]: got %0d want %0d", k, samp[k], exp_tri[k]);
                end
            end
        end
    endtask

    task automatic test_square();
        int hi;
        int lo;
        do_reset(2'd2, 24'h100000, 12'd1024, 8'd128);
        collect(16, 100);
        hi = 0; lo = 0;
        foreach (samp[k]) begin
            if (samp[k] == 2047) hi++;
            if (samp[k] == -2048) lo++;
        end
        n_total++;
        if (hi != 4 || lo != 12) begin
            n_bad++;
            $display("FAIL sqr_duty1024: got high=%0d low=%0d want 4/12", hi, lo);
        end
        do_reset(2'd2, 24'h100000, 12'd0, 8'd128);
        collect(16, 100);
        lo = 0;
        foreach (samp[k]) if (samp[k] == -2048) lo++;
        n_total++;
        if (lo != 16) begin
            n_bad++;
            $display("FAIL sqr_duty0: got %0d low samples want 16", lo);
        end
    endtask

    task automatic test_switch();
        int got[$];
        bit seen_wrap;
        do_reset(2'd1, 24'h100000, 12'd0, 8'd128);
        collect(5, 60);
        wave_sel = 2'd2;
        duty = 12'd2048;
        for (int i = 0; i < 80 && got.size() < 12; i++) begin
            @(negedge clk);
            n_total++;
            if (pcm !== exp_pcm || pcm_valid !== exp_valid || wrap !== exp_wrap) begin
                n_bad++;
                $display("FAIL switch_model: got pcm=%0d v=%b w=%b want %0d/%b/%b",
                         pcm, pcm_valid, wrap, exp_pcm, exp_valid, exp_wrap);
            end
            if (pcm_valid) got.push_back(int'(pcm));
        end
        n_total++;
        if (got.size() != 12 || got[9] != 1792 || got[10] != 2047 || got[11] != 2047) begin
            n_bad++;
            $display("FAIL switch_at_wrap: got n=%0d last saw=%0d first sqr=%0d want 12/1792/2047",
                     got.size(), (got.size() > 9) ? got[9] : 0, (got.size() > 10) ? got[10] : 0);
        end
        wave_sel = 2'd1;
        sync = 1'b1;
        got.delete();
        seen_wrap = 1'b0;
        for (int i = 0; i < 40 && got.size() < 2; i++) begin
            @(negedge clk);
            n_total++;
            if (pcm !== exp_pcm || pcm_valid !== exp_valid || wrap !== exp_wrap) begin
                n_bad++;
                $display("FAIL sync_model: got pcm=%0d v=%b w=%b want %0d/%b/%b",
                         pcm, pcm_valid, wrap, exp_pcm, exp_valid, exp_wrap);
            end
            if (wrap) begin
                seen_wrap = 1'b1;
                sync = 1'b0;
            end
            if (pcm_valid && seen_wrap) got.push_back(int'(pcm));
        end
        n_total++;
        if (got.size() != 2 || got[0] != -2048 || got[1] != -1792) begin
            n_bad++;
            $display("FAIL sync_restart: got n=%0d first=%0d second=%0d want 2/-2048/-1792",
                     got.size(), (got.size() > 0) ? got[0] : 0, (got.size() > 1) ? got[1] : 0);
        end
        sync = 1'b0;
    endtask

    task automatic test_gain();
        do_reset(2'd1, 24'h100000, 12'd0, 8'd64);
        collect(1, 40);
        n_total++;
        if (samp.size() != 1 || samp[0] != -896) begin
            n_bad++;
            $display("FAIL gain_half: got %0d want -896", (samp.size() > 0) ? samp[0] : 0);
        end
        do_reset(2'd1, 24'h100000, 12'd0, 8'd255);
        collect(16, 100);
        n_total++;
        if (samp.size() != 16 || samp[0] != -2048 || samp[7] != 0 || samp[14] != 2047) begin
            n_bad++;
            $display("FAIL gain_sat: got n=%0d s0=%0d s7=%0d s14=%0d want 16/-2048/0/2047",
                     samp.size(), (samp.size() > 0) ? samp[0] : 0,
                     (samp.size() > 7) ? samp[7] : 0, (samp.size() > 14) ? samp[14] : 0);
        end
        do_reset(2'd1, 24'h100000, 12'd0, 8'd0);
        collect(4, 40);
        n_total++;
        if (samp.size() != 4 || samp[0] != 0 || samp[1] != 0 || samp[2] != 0 || samp[3] != 0) begin
            n_bad++;
            $display("FAIL gain_zero: got n=%0d s0=%0d want 4 zero samples",
                     samp.size(), (samp.size() > 0) ? samp[0] : 0);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_reset(2'd1, 24'h100000, 12'd0, 8'd128);
        collect(3, 40);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_total++;
        if (pcm !== 12'sd0 || pcm_valid !== 1'b0 || wrap !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_clear: got pcm=%0d valid=%b wrap=%b want 0/0/0", pcm, pcm_valid, wrap);
        end
        @(negedge clk);
        rstn = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            n_total++;
            if (pcm !== exp_pcm || pcm_valid !== exp_valid || wrap !== exp_wrap) begin
                n_bad++;
                $display("FAIL midreset_model: got pcm=%0d v=%b w=%b want %0d/%b/%b",
                         pcm, pcm_valid, wrap, exp_pcm, exp_valid, exp_wrap);
            end
            if (pcm_valid) lat = i;
        end
        n_total++;
        if (lat != DIV + 1) begin
            n_bad++;
            $display("FAIL midreset_latency: got %0d clocks want %0d", lat, DIV + 1);
        end
    endtask

    task automatic test_random();
        do_reset(2'($urandom_range(0, 3)), 24'($urandom_range(0, 1 << 20)), 12'($urandom), 8'($urandom));
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            n_total++;
            if (pcm !== exp_pcm || pcm_valid !== exp_valid || wrap !== exp_wrap) begin
                n_bad++;
                $display("FAIL random_model: cycle %0d got pcm=%0d v=%b w=%b want %0d/%b/%b",
                         i, pcm, pcm_valid, wrap, exp_pcm, exp_valid, exp_wrap);
            end
            if ($urandom_range(0, 15) == 0) begin
                wave_sel = 2'($urandom_range(0, 3));
                duty     = 12'($urandom);
                amp      = 8'($urandom);
                ftw      = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 1 << 20));
            end
            sync = ($urandom_range(0, 40) == 0);
        end
        sync = 1'b0;
    endtask

    initial begin
        test_reset();
        test_saw();
        test_triangle();
        test_square();
        test_switch();
        test_gain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wavegen_dds.md
Name: wavegen_dds

Overview:
- Parametrised successor to the fixed-slope triangle generator used in the audio examples.
- Generates triangle, sawtooth or square PCM through a phase accumulator (DDS) with run-time frequency, duty cycle and amplitude gain, including saturation.
- Waveform changes are glitch-free and take effect at phase wrap. Sample rate comes from an internal prescaler.
- Output feeds the PWM/DAC stage: a signed PCM word plus a one-cycle valid strobe per sample.

Parameters:
- C_pcm_bits, 12: PCM output width W (signed).
- C_phase_bits, 24: phase accumulator width P; P >= W+2.
- C_amp_bits, 8: amplitude gain width A; unity gain = 2^(A-1).
- C_div, 1024: clocks per sample tick; >= 3.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- ftw  in  P  frequency tuning word (unsigned phase increment per tick)
- wave_sel  in  2  0=triangle, 1=saw, 2=square, 3=silence
- duty  in  W  square threshold (unsigned, compared to phase MSBs)
- amp  in  A  gain, unsigned, amp/2^(A-1)
- sync  in  1  level; phase restart request, serviced at next tick
- pcm  out  W  signed sample
- pcm_valid  out  1  one-cycle pulse when pcm updates
- wrap  out  1  one-cycle pulse on tick where phase carried out or was synced

Behaviour:
- Reset (async assert, sync release): prescaler=0, phase=0, sel_q=3 (silence), duty_q=0, stage regs=0, pcm=0, pcm_valid=0, wrap=0.
- Prescaler counts 0..C_div-1; tick is asserted in the cycle the count equals C_div-1, then the count returns to 0.
- On tick: phase <= phase + ftw (mod 2^P). ftw is sampled every tick, so frequency changes are phase-continuous.
- If sync=1 on tick: phase <= 0 instead, overriding the add. wrap=1.
- Otherwise wrap = carry-out of the add.
- sel_q/duty_q latch wave_sel/duty on any tick where wrap=1, or where sel_q=3. Mid-cycle changes are deferred to the next wrap; leaving silence is immediate at the next tick.
- Raw waveform (stage 1, registered in the cycle after tick, from the updated phase). Let u = phase[P-1:P-W] and v = phase[P-2:P-1-W]:
  - saw: u - 2^(W-1)
  - triangle: (phase[P-1] ? ~v : v) - 2^(W-1)
  - square: (u < duty_q) ? 2^(W-1)-1 : -2^(W-1). duty_q=0 gives constant low.
  - silence: 0
- Stage 2 (next cycle):
  - prod = raw * amp, signed W+A+1 bits, amp zero-extended.
  - s = prod >>> (A-1), arithmetic shift (rounds toward -inf).
  - Saturate s to [-2^(W-1), 2^(W-1)-1] and register into pcm; pcm_valid=1 for exactly that cycle.
- Latency: tick at cycle N -> pcm/pcm_valid at cycle N+2. wrap is registered and pulses at N+1.
- pcm holds its value between valid pulses.
- amp=0 -> pcm=0. amp > unity -> saturates, never wraps.
- ftw=0 -> phase frozen, pcm constant, valid still pulses each tick.
- ftw >= 2^(P-1) aliases; this is legal and performs no special handling.
- Reset mid-operation clears the whole pipeline. No stale valid pulse is emitted after release.

Decomposition:
- Shared package wavegen_pkg:
  - wave_sel encodings WAVE_TRI/WAVE_SAW/WAVE_SQR/WAVE_OFF
  - helper function for signed saturation to W bits
- One natural sub-module: wavegen_shaper, the combinational raw-waveform mux plus gain/saturate stage. Phase, prescaler, latching and pipeline registers stay in the top.

Test Plan (P=24, W=12, A=8, C_div=4 unless stated):
1. Reset, then wave_sel=1, ftw=2^20, amp=128:
   - First valid pcm = -1792, then -1536, -1280 in steps of 256.
   - After 16 ticks pcm=-2048 and wrap pulses.
   - Valid spacing is 4 clocks; valid lands 2 clocks after each tick.
2. wave_sel=0, ftw=2^20, amp=128:
   - pcm = -1536, -1024, -512, 0, 512, 1024, 1536, 2047, 1535, ... back to -2048 at wrap.
   - Symmetric rise and fall.
3. wave_sel=2, duty=1024, ftw=2^20: pcm=2047 for 4 of 16 samples, -2048 otherwise. duty=0 -> always -2048.
4. Saw running, switch wave_sel 1->2 at mid-cycle: saw continues until the wrap pulse, square starts on the first sample after wrap. Repeat with sync=1: switch at the next tick, phase=0.
5. Gain:
   - amp=64 on saw halves values (-1792 -> -896).
   - amp=255 saturates to 2047/-2048.
   - amp=0 gives pcm=0.
6. Assert rstn low mid-stream for 1 cycle: pcm=0, pcm_valid=0 immediately. After release, first valid comes C_div+1 clocks later with sel_q=silence until first tick.
